// File: rtl/encoder_pkg.sv
// Shared constants for the sequential 4-to-2 encoder and its priority selector.
package encoder_pkg;

  localparam int unsigned CODE_W  = 2;
  localparam int unsigned N_LINES = 4;

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_PRESENT = 1'b1;

endpackage

// File: rtl/priority_select_4.sv
// Combinational 4-way request selector: fixed (highest index wins) or
// round-robin (first set index at or after start, modulo 4).
module priority_select_4
  import encoder_pkg::*;
(
  input  logic [N_LINES-1:0] pending,
  input  logic [CODE_W-1:0]  start,
  input  logic               ROTATE,
  output logic [CODE_W-1:0]  sel,
  output logic               any
);

  logic [CODE_W-1:0] idx;

  always_comb begin
    sel = '0;
    idx = '0;
    any = |pending;
    if (ROTATE) begin
      // Walk offsets from farthest to nearest so the nearest set index is the last write.
      for (int unsigned k = N_LINES; k > 0; k--) begin
        idx = start + CODE_W'(k - 1);
        if (pending[idx]) sel = idx;
      end
    end else begin
      for (int unsigned k = 0; k < N_LINES; k++) begin
        if (pending[k]) sel = CODE_W'(k);
      end
    end
  end

endmodule

// File: rtl/encoder_4_to_2_seq.sv
// Sequential 4-to-2 encoder: OR-merges line requests into a pending register and
// presents one code at a time, held until acknowledged.
module encoder_4_to_2_seq
  import encoder_pkg::*;
#(
  parameter logic ROTATE = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic ACK,
  output logic A0,
  output logic A1,
  output logic V
);

  logic [N_LINES-1:0] pending_q, pending_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  last_q, last_d;
  logic               state_q, state_d;

  logic [N_LINES-1:0] cap;
  logic [N_LINES-1:0] served_mask;
  logic [N_LINES-1:0] cleared;
  logic [N_LINES-1:0] sel_in;
  logic [CODE_W-1:0]  sel_start;
  logic [CODE_W-1:0]  sel;
  logic               sel_any;
  logic               ack_fire;

  assign cap      = EN ? {D3, D2, D1, D0} : '0;
  assign ack_fire = (state_q == ST_PRESENT) && ACK;

  always_comb begin
    served_mask         = '0;
    served_mask[code_q] = 1'b1;
  end

  assign cleared = pending_q & ~served_mask;

  // On ACK the next code comes from what remains pending; same-edge captures only
  // matter when nothing else remains, which keeps a re-requested line presented.
  always_comb begin
    sel_in    = pending_q;
    sel_start = last_q + 2'd1;
    if (ack_fire) begin
      sel_in    = (|cleared) ? cleared : cap;
      sel_start = code_q + 2'd1;
    end
  end

  priority_select_4 u_sel (
    .pending (sel_in),
    .start   (sel_start),
    .ROTATE  (ROTATE),
    .sel     (sel),
    .any     (sel_any)
  );

  always_comb begin
    pending_d = (ack_fire ? cleared : pending_q) | cap;
    state_d   = state_q;
    code_d    = code_q;
    last_d    = last_q;
    if (state_q == ST_IDLE) begin
      if (sel_any) begin
        code_d  = sel;
        state_d = ST_PRESENT;
      end
    end else if (ACK) begin
      last_d = code_q;
      if (sel_any) code_d  = sel;
      else         state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_q <= '0;
      state_q   <= ST_IDLE;
      code_q    <= '0;
      last_q    <= 2'd3;
    end else begin
      pending_q <= pending_d;
      state_q   <= state_d;
      code_q    <= code_d;
      last_q    <= last_d;
    end
  end

  assign A1 = code_q[1];
  assign A0 = code_q[0];
  assign V  = state_q;

endmodule

// File: tb/tb_encoder_4_to_2_seq.sv
// Scoreboard bench for encoder_4_to_2_seq: fixed-priority and round-robin instances.
module tb_encoder_4_to_2_seq;

  logic CLK = 1'b0;
  logic RST, EN, D0, D1, D2, D3, ACK;
  logic fA0, fA1, fV, rA0, rA1, rV;
  logic [1:0] fcode, rcode;
  logic [1:0] exp_q[$];
  logic [1:0] exp;
  int checks   = 0;
  int failures = 0;
  int n;

  assign fcode = {fA1, fA0};
  assign rcode = {rA1, rA0};

  always #5 CLK = ~CLK;

  encoder_4_to_2_seq #(.ROTATE(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .EN(EN), .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .ACK(ACK), .A0(fA0), .A1(fA1), .V(fV)
  );

  encoder_4_to_2_seq #(.ROTATE(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .EN(EN), .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .ACK(ACK), .A0(rA0), .A1(rA1), .V(rV)
  );

  task automatic do_reset;
    @(negedge CLK);
    {D3, D2, D1, D0} = 4'b0000;
    EN  = 1'b0;
    ACK = 1'b0;
    RST = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (fV !== 1'b0 || fcode !== 2'b00) begin
      failures++;
      $display("FAIL reset_state: V=%b A=%b, want V=0 A=00", fV, fcode);
    end
    EN = 1'b1; D1 = 1'b1; D3 = 1'b1;
    @(negedge CLK);
    EN = 1'b0; D1 = 1'b0; D3 = 1'b0;
    @(negedge CLK);
    checks++;
    if (fV !== 1'b1 || fcode !== 2'b11 || dut0.pending_q !== 4'b1010) begin
      failures++;
      $display("FAIL reset_setup: V=%b A=%b pend=%b, want V=1 A=11 pend=1010", fV, fcode, dut0.pending_q);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (fV !== 1'b0 || fcode !== 2'b00 || dut0.pending_q !== 4'b0000) begin
      failures++;
      $display("FAIL reset_async: V=%b A=%b pend=%b, want V=0 A=00 pend=0000", fV, fcode, dut0.pending_q);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      checks++;
      if (fV !== 1'b0) begin
        failures++;
        $display("FAIL reset_quiet: V=%b, want 0", fV);
      end
    end
  endtask

  task automatic test_single;
    do_reset();
    EN = 1'b1; D2 = 1'b1;
    exp_q.push_back(2'b10);
    @(negedge CLK);
    EN = 1'b0; D2 = 1'b0;
    checks++;
    if (fV !== 1'b0) begin
      failures++;
      $display("FAIL single_latency: V=%b after first edge, want 0", fV);
    end
    @(negedge CLK);
    exp = exp_q.pop_front();
    checks++;
    if (fV !== 1'b1 || fcode !== exp) begin
      failures++;
      $display("FAIL single_present: V=%b A=%b, want V=1 A=%b", fV, fcode, exp);
    end
    repeat (5) begin
      @(negedge CLK);
      checks++;
      if (fV !== 1'b1 || fcode !== exp) begin
        failures++;
        $display("FAIL single_hold: V=%b A=%b, want V=1 A=%b", fV, fcode, exp);
      end
    end
    ACK = 1'b1;
    @(negedge CLK);
    ACK = 1'b0;
    checks++;
    if (fV !== 1'b0 || fcode !== 2'b10) begin
      failures++;
      $display("FAIL single_release: V=%b A=%b, want V=0 A=10", fV, fcode);
    end
  endtask

  task automatic test_fixed_priority;
    do_reset();
    EN = 1'b1; D0 = 1'b1; D1 = 1'b1; D3 = 1'b1;
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b00);
    @(negedge CLK);
    EN = 1'b0; D0 = 1'b0; D1 = 1'b0; D3 = 1'b0;
    n = 0;
    while (fV !== 1'b1 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (fV !== 1'b1) begin
      failures++;
      $display("FAIL fixed_timeout: V=%b, want 1 within 10 cycles", fV);
    end
    repeat (3) begin
      exp = exp_q.pop_front();
      checks++;
      if (fV !== 1'b1 || fcode !== exp) begin
        failures++;
        $display("FAIL fixed_order: V=%b A=%b, want V=1 A=%b", fV, fcode, exp);
      end
      ACK = 1'b1;
      @(negedge CLK);
    end
    ACK = 1'b0;
    checks++;
    if (fV !== 1'b0) begin
      failures++;
      $display("FAIL fixed_drain: V=%b, want 0", fV);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    EN = 1'b1; D1 = 1'b1; D3 = 1'b1; ACK = 1'b1;
    repeat (2) begin
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b11);
    end
    n = 0;
    while (rV !== 1'b1 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (rV !== 1'b1) begin
      failures++;
      $display("FAIL rr_timeout: V=%b, want 1 within 10 cycles", rV);
    end
    repeat (4) begin
      exp = exp_q.pop_front();
      checks++;
      if (rV !== 1'b1 || rcode !== exp) begin
        failures++;
        $display("FAIL rr_order: V=%b A=%b, want V=1 A=%b", rV, rcode, exp);
      end
      @(negedge CLK);
    end
    EN = 1'b0; D1 = 1'b0; D3 = 1'b0; ACK = 1'b0;
  endtask

  task automatic test_gating;
    do_reset();
    EN = 1'b0; {D3, D2, D1, D0} = 4'b1111;
    repeat (4) begin
      @(negedge CLK);
      checks++;
      if (fV !== 1'b0) begin
        failures++;
        $display("FAIL gate_blocked: V=%b, want 0", fV);
      end
    end
    EN = 1'b1;
    exp_q.push_back(2'b11);
    @(negedge CLK);
    EN = 1'b0; {D3, D2, D1, D0} = 4'b0000;
    checks++;
    if (fV !== 1'b0) begin
      failures++;
      $display("FAIL gate_latency: V=%b, want 0", fV);
    end
    @(negedge CLK);
    exp = exp_q.pop_front();
    checks++;
    if (fV !== 1'b1 || fcode !== exp) begin
      failures++;
      $display("FAIL gate_present: V=%b A=%b, want V=1 A=%b", fV, fcode, exp);
    end
  endtask

  task automatic test_same_edge;
    do_reset();
    EN = 1'b1; D2 = 1'b1;
    exp_q.push_back(2'b10);
    @(negedge CLK);
    EN = 1'b0; D2 = 1'b0;
    @(negedge CLK);
    exp = exp_q.pop_front();
    checks++;
    if (fV !== 1'b1 || fcode !== exp) begin
      failures++;
      $display("FAIL same_setup: V=%b A=%b, want V=1 A=%b", fV, fcode, exp);
    end
    ACK = 1'b1; EN = 1'b1; D2 = 1'b1;
    exp_q.push_back(2'b10);
    @(negedge CLK);
    ACK = 1'b0; EN = 1'b0; D2 = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (fV !== 1'b1 || fcode !== exp || dut0.pending_q !== 4'b0100) begin
      failures++;
      $display("FAIL same_rerequest: V=%b A=%b pend=%b, want V=1 A=%b pend=0100", fV, fcode, dut0.pending_q, exp);
    end
    ACK = 1'b1;
    @(negedge CLK);
    ACK = 1'b0;
    checks++;
    if (fV !== 1'b0) begin
      failures++;
      $display("FAIL same_single_count: V=%b, want 0", fV);
    end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; ACK = 1'b0;
    {D3, D2, D1, D0} = 4'b0000;
    test_reset();
    test_single();
    test_fixed_priority();
    test_round_robin();
    test_gating();
    test_same_edge();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: %0d entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
